// File: rtl/regfile_pkg.sv
// Shared register-file geometry used by the write-back queue and the regfile.
package regfile_pkg;
    localparam int DATA_W   = 64;
    localparam int ADDR_W   = 6;
    localparam int NUM_REGS = 32;
endpackage

// File: rtl/regfile_write_queue_if.sv
// Producer handshake plus regfile write port of the write-back queue.
interface regfile_write_queue_if;
    import regfile_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_addr;
    logic [DATA_W-1:0] in_data;
    logic              drain_en;
    logic              write_en;
    logic [ADDR_W-1:0] write_addr;
    logic [DATA_W-1:0] write_data;

    // Master is the pipeline side (producer plus regfile); slave is the queue.
    modport master (
        output in_valid, in_addr, in_data, drain_en,
        input  in_ready, write_en, write_addr, write_data
    );

    modport slave (
        input  in_valid, in_addr, in_data, drain_en,
        output in_ready, write_en, write_addr, write_data
    );
endinterface

// File: rtl/regfile_fwd_lookup.sv
// Searches the queued entries for chk_addr and returns the youngest match.
module regfile_fwd_lookup
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic [ADDR_W-1:0] addr_arr [DEPTH],
    input  logic [DATA_W-1:0] data_arr [DEPTH],
    input  logic [PTR_W-1:0]  rd_ptr,
    input  logic [CNT_W-1:0]  count,
    input  logic [ADDR_W-1:0] chk_addr,
    output logic              pending,
    output logic [DATA_W-1:0] fwd_data
);

    logic [PTR_W-1:0] idx;

    // Walk oldest to youngest so later matches overwrite earlier ones.
    always_comb begin
        pending  = 1'b0;
        fwd_data = '0;
        idx      = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr + PTR_W'(k);
            if ((CNT_W'(k) < count) && (addr_arr[idx] == chk_addr)) begin
                pending  = 1'b1;
                fwd_data = data_arr[idx];
            end
        end
    end

endmodule

// File: rtl/regfile_write_queue.sv
// Write-back FIFO in front of the register file with two read-port forwarding lookups.
module regfile_write_queue
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    regfile_write_queue_if.slave  bus,
    input  logic [ADDR_W-1:0]     chk_addr_a,
    output logic                  pending_a,
    output logic [DATA_W-1:0]     fwd_data_a,
    input  logic [ADDR_W-1:0]     chk_addr_b,
    output logic                  pending_b,
    output logic [DATA_W-1:0]     fwd_data_b
);

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic accept, push, pop;
    logic pend_a_raw, pend_b_raw;
    logic [DATA_W-1:0] fwd_a_raw, fwd_b_raw;

    // in_ready looks only at state so the producer never sees a path from drain_en.
    assign bus.in_ready = !reset && (count_q < CNT_W'(DEPTH));
    assign accept       = bus.in_valid && bus.in_ready;
    assign push         = accept && (bus.in_addr < ADDR_W'(NUM_REGS));

    assign bus.write_en   = !reset && (count_q != '0) && bus.drain_en;
    assign pop            = bus.write_en;
    assign bus.write_addr = bus.write_en ? addr_q[rd_ptr_q] : '0;
    assign bus.write_data = bus.write_en ? data_q[rd_ptr_q] : '0;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage needs no reset: count gates every use of it.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wr_ptr_q] <= bus.in_addr;
            data_q[wr_ptr_q] <= bus.in_data;
        end
    end

    regfile_fwd_lookup #(.DEPTH(DEPTH)) u_fwd_a (
        .addr_arr (addr_q),
        .data_arr (data_q),
        .rd_ptr   (rd_ptr_q),
        .count    (count_q),
        .chk_addr (chk_addr_a),
        .pending  (pend_a_raw),
        .fwd_data (fwd_a_raw)
    );

    regfile_fwd_lookup #(.DEPTH(DEPTH)) u_fwd_b (
        .addr_arr (addr_q),
        .data_arr (data_q),
        .rd_ptr   (rd_ptr_q),
        .count    (count_q),
        .chk_addr (chk_addr_b),
        .pending  (pend_b_raw),
        .fwd_data (fwd_b_raw)
    );

    assign pending_a  = !reset && pend_a_raw;
    assign fwd_data_a = reset ? '0 : fwd_a_raw;
    assign pending_b  = !reset && pend_b_raw;
    assign fwd_data_b = reset ? '0 : fwd_b_raw;

endmodule

// File: tb/tb_regfile_write_queue.sv
// Directed self-checking bench for regfile_write_queue.
module tb_regfile_write_queue;
    import regfile_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] chk_addr_a, chk_addr_b;
    logic              pending_a, pending_b;
    logic [DATA_W-1:0] fwd_data_a, fwd_data_b;

    int checks   = 0;
    int failures = 0;

    regfile_write_queue_if bus ();

    regfile_write_queue #(.DEPTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus.slave),
        .chk_addr_a (chk_addr_a),
        .pending_a  (pending_a),
        .fwd_data_a (fwd_data_a),
        .chk_addr_b (chk_addr_b),
        .pending_b  (pending_b),
        .fwd_data_b (fwd_data_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        bus.in_valid = 1'b1;
        bus.in_addr  = a;
        bus.in_data  = d;
        step();
        bus.in_valid = 1'b0;
    endtask

    initial begin
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_addr  = '0;
        bus.in_data  = '0;
        bus.drain_en = 1'b0;
        chk_addr_a   = '0;
        chk_addr_b   = '0;
        #1;
        check("rst_in_ready", 64'(bus.in_ready), 64'd0);
        check("rst_write_en", 64'(bus.write_en), 64'd0);
        step();
        step();
        reset = 1'b0;
        bus.drain_en = 1'b1;
        #1;
        check("idle_in_ready", 64'(bus.in_ready), 64'd1);
        check("idle_write_en", 64'(bus.write_en), 64'd0);
        check("idle_pending_a", 64'(pending_a), 64'd0);
        check("idle_pending_b", 64'(pending_b), 64'd0);

        // Single result: visible on the write port the cycle after acceptance.
        chk_addr_a   = 6'd5;
        bus.in_valid = 1'b1;
        bus.in_addr  = 6'd5;
        bus.in_data  = 64'hAAAA;
        #1;
        check("no_same_cycle_fwd", 64'(pending_a), 64'd0);
        check("empty_no_write", 64'(bus.write_en), 64'd0);
        step();
        bus.in_valid = 1'b0;
        check("lat_write_en", 64'(bus.write_en), 64'd1);
        check("lat_write_addr", 64'(bus.write_addr), 64'd5);
        check("lat_write_data", bus.write_data, 64'hAAAA);
        check("lat_pending_a", 64'(pending_a), 64'd1);
        check("lat_fwd_a", fwd_data_a, 64'hAAAA);
        step();
        check("lat_empty_after", 64'(bus.write_en), 64'd0);
        check("lat_pending_gone", 64'(pending_a), 64'd0);

        // Fill to full with drain held off, then drain in order.
        bus.drain_en = 1'b0;
        push(6'd3, 64'd1);
        push(6'd4, 64'd2);
        push(6'd5, 64'd3);
        check("not_full_3", 64'(bus.in_ready), 64'd1);
        push(6'd6, 64'd4);
        check("full_in_ready", 64'(bus.in_ready), 64'd0);
        check("held_write_en", 64'(bus.write_en), 64'd0);
        check("held_write_addr", 64'(bus.write_addr), 64'd0);
        // Offer a push while full and popping: it must not be taken.
        bus.drain_en = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_addr  = 6'd9;
        bus.in_data  = 64'h99;
        #1;
        check("drain0_addr", 64'(bus.write_addr), 64'd3);
        check("drain0_data", bus.write_data, 64'd1);
        step();
        bus.in_valid = 1'b0;
        check("ready_after_pop", 64'(bus.in_ready), 64'd1);
        check("drain1_addr", 64'(bus.write_addr), 64'd4);
        check("drain1_data", bus.write_data, 64'd2);
        step();
        check("drain2_addr", 64'(bus.write_addr), 64'd5);
        check("drain2_data", bus.write_data, 64'd3);
        step();
        check("drain3_addr", 64'(bus.write_addr), 64'd6);
        check("drain3_data", bus.write_data, 64'd4);
        step();
        check("drained_empty", 64'(bus.write_en), 64'd0);

        // Same address twice: youngest forwarded, both written oldest first.
        bus.drain_en = 1'b0;
        push(6'd7, 64'h11);
        chk_addr_a = 6'd7;
        chk_addr_b = 6'd7;
        #1;
        check("fwd_one_b", fwd_data_b, 64'h11);
        push(6'd7, 64'h22);
        chk_addr_b = 6'd8;
        #1;
        check("dup_pending_a", 64'(pending_a), 64'd1);
        check("dup_fwd_a", fwd_data_a, 64'h22);
        check("miss_pending_b", 64'(pending_b), 64'd0);
        check("miss_fwd_b", fwd_data_b, 64'd0);
        bus.drain_en = 1'b1;
        #1;
        check("dup_w0_data", bus.write_data, 64'h11);
        check("dup_head_pending", 64'(pending_a), 64'd1);
        step();
        check("dup_w1_data", bus.write_data, 64'h22);
        check("dup_w1_fwd", fwd_data_a, 64'h22);
        step();
        check("dup_done_pending", 64'(pending_a), 64'd0);
        check("dup_done_fwd", fwd_data_a, 64'd0);

        // Out-of-range address: handshake completes, nothing queued.
        bus.in_valid = 1'b1;
        bus.in_addr  = 6'd40;
        bus.in_data  = 64'hFFFF;
        chk_addr_a   = 6'd40;
        #1;
        check("oor_in_ready", 64'(bus.in_ready), 64'd1);
        step();
        bus.in_valid = 1'b0;
        check("oor_write_en", 64'(bus.write_en), 64'd0);
        check("oor_pending", 64'(pending_a), 64'd0);
        step();
        check("oor_write_en2", 64'(bus.write_en), 64'd0);

        // Steady push+pop at count=2 across several pointer wraps.
        bus.drain_en = 1'b0;
        push(6'd1, 64'd100);
        push(6'd2, 64'd101);
        bus.drain_en = 1'b1;
        for (int k = 0; k < 20; k++) begin
            bus.in_valid = 1'b1;
            bus.in_addr  = 6'(((k + 2) % 30) + 1);
            bus.in_data  = 64'(102 + k);
            #1;
            check("wrap_in_ready", 64'(bus.in_ready), 64'd1);
            check("wrap_data", bus.write_data, 64'(100 + k));
            check("wrap_addr", 64'(bus.write_addr), 64'((k % 30) + 1));
            step();
        end
        bus.in_valid = 1'b0;
        #1;
        check("wrap_tail0", bus.write_data, 64'd120);
        step();
        check("wrap_tail1", bus.write_data, 64'd121);
        step();
        check("wrap_empty", 64'(bus.write_en), 64'd0);

        // Asynchronous reset while draining three queued entries.
        bus.drain_en = 1'b0;
        push(6'd10, 64'hA);
        push(6'd11, 64'hB);
        push(6'd12, 64'hC);
        bus.drain_en = 1'b1;
        chk_addr_a   = 6'd11;
        #1;
        check("pre_rst_write_en", 64'(bus.write_en), 64'd1);
        check("pre_rst_pending", 64'(pending_a), 64'd1);
        #1;
        reset = 1'b1;
        #1;
        check("mid_rst_write_en", 64'(bus.write_en), 64'd0);
        check("mid_rst_in_ready", 64'(bus.in_ready), 64'd0);
        check("mid_rst_pending", 64'(pending_a), 64'd0);
        check("mid_rst_fwd", fwd_data_a, 64'd0);
        step();
        reset = 1'b0;
        #1;
        check("post_rst_write_en", 64'(bus.write_en), 64'd0);
        check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
        step();
        check("post_rst_empty", 64'(bus.write_en), 64'd0);
        check("post_rst_pending", 64'(pending_a), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
